base_router_rob: RTL and testbench

- Parametrised, pipelined successor to the single-op base router.
- Accepts ops on a valid/ready stream and chooses base-2, base-10 or base-12 per op, automatically or by forced mode.
- Dispatches each op to one of three external ALU channels with per-channel handshakes; channel responses may return out of order.
- A DEPTH-entry reorder buffer retires results in issue order; per-base dispatch counters support profiling.

---
 rtl/base_router_rob_pkg.sv | 60 ++++++
 rtl/base_router_rob_if.sv | 40 ++++
 rtl/base_router_rob_rob_ctrl.sv | 123 ++++++++++++
 rtl/base_router_rob.sv | 79 +++++++
 tb/tb_base_router_rob.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/base_router_rob_pkg.sv
// Shared encodings and the base-selection rule for the reorder-buffered base router.
// The bench's model reuses select_base.
package base_router_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;

  typedef enum logic [1:0] {
    MODE_AUTO = 2'b00,
    MODE_B2   = 2'b01,
    MODE_B10  = 2'b10,
    MODE_B12  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    BASE2  = 2'd0,
    BASE10 = 2'd1,
    BASE12 = 2'd2
  } base_e;

  // Operands arrive zero-extended to 32 bits so one function serves any WIDTH up to 32.
  function automatic logic [1:0] select_base(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op, input logic [1:0] mode);
    logic a12, b12, a10, b10;
    logic [1:0] res;
    a12 = (a % 32'd12) == 32'd0;
    b12 = (b % 32'd12) == 32'd0;
    a10 = (a % 32'd10) == 32'd0;
    b10 = (b % 32'd10) == 32'd0;
    res = BASE2;
    if (op <= OP_DIV) begin
      case (mode)
        MODE_B2:  res = BASE2;
        MODE_B10: res = BASE10;
        MODE_B12: res = BASE12;
        default: begin
          if (op == OP_MUL) begin
            if (a12 || b12)      res = BASE12;
            else if (a10 || b10) res = BASE10;
          end else if (op == OP_DIV) begin
            if (b == 32'd12 || b == 32'd6 || b == 32'd4 || b == 32'd3) res = BASE12;
            else if (b == 32'd10 || b == 32'd5)                       res = BASE10;
          end else begin
            if (a12 && b12)      res = BASE12;
            else if (a10 && b10) res = BASE10;
          end
        end
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/base_router_rob_if.sv
// Op stream, three ALU channels and the in-order result stream of the base router.
interface base_router_rob_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 3
);
  // Every stream transfers on a cycle where valid && ready; valid never waits on ready.
  // ALU responses have no ready: they are always accepted.
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [3:0]         in_op;
  logic [2:0]         alu_req_valid;
  logic [2:0]         alu_req_ready;
  logic [WIDTH-1:0]   alu_req_a;
  logic [WIDTH-1:0]   alu_req_b;
  logic [3:0]         alu_req_op;
  logic [TAG_W-1:0]   alu_req_tag;
  logic [2:0]         alu_rsp_valid;
  logic [3*WIDTH-1:0] alu_rsp_data;
  logic [3*TAG_W-1:0] alu_rsp_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_base;

  modport slave (
    input  in_valid, in_a, in_b, in_op, alu_req_ready, alu_rsp_valid, alu_rsp_data,
           alu_rsp_tag, out_ready,
    output in_ready, alu_req_valid, alu_req_a, alu_req_b, alu_req_op, alu_req_tag,
           out_valid, out_data, out_base
  );

  modport master (
    output in_valid, in_a, in_b, in_op, alu_req_ready, alu_rsp_valid, alu_rsp_data,
           alu_rsp_tag, out_ready,
    input  in_ready, alu_req_valid, alu_req_a, alu_req_b, alu_req_op, alu_req_tag,
           out_valid, out_data, out_base
  );
endinterface

// File: rtl/base_router_rob_rob_ctrl.sv
// Reorder buffer: slot array with three response write ports, head/tail/count and
// a registered retire stage that presents results in issue order.
module rob_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fire,
  input  logic [1:0]         fire_base,
  input  logic [2:0]         rsp_valid,
  input  logic [3*WIDTH-1:0] rsp_data,
  input  logic [3*TAG_W-1:0] rsp_tag,
  input  logic               out_ready,
  output logic [TAG_W-1:0]   tail,
  output logic               full,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_base,
  output logic               err_tag
);
  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0] pending_q, pending_d, done_q, done_d;
  logic [1:0]       base_q [DEPTH];
  logic [1:0]       base_d [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, slot;
  logic [TAG_W:0]   count_q, count_d;
  logic             out_valid_q, out_valid_d, err_q, err_d, pop;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_base_q, out_base_d;

  assign pop = out_valid_q && out_ready;

  always_comb begin
    pending_d = pending_q;
    done_d    = done_q;
    base_d    = base_q;
    data_d    = data_q;
    head_d    = head_q;
    tail_d    = tail_q;
    err_d     = err_q;
    slot      = '0;
    if (pop) begin
      pending_d[head_q] = 1'b0;
      done_d[head_q]    = 1'b0;
      head_d            = head_q + 1'b1;
    end
    // Judged against registered state, so a same-cycle dispatch or retire never legitimises a response.
    for (int c = 0; c < 3; c++) begin
      if (rsp_valid[c]) begin
        slot = rsp_tag[c*TAG_W +: TAG_W];
        if (pending_q[slot] && !done_q[slot] && base_q[slot] == 2'(c)) begin
          done_d[slot] = 1'b1;
          data_d[slot] = rsp_data[c*WIDTH +: WIDTH];
        end else begin
          err_d = 1'b1;
        end
      end
    end
    if (fire) begin
      pending_d[tail_q] = 1'b1;
      done_d[tail_q]    = 1'b0;
      base_d[tail_q]    = fire_base;
      tail_d            = tail_q + 1'b1;
    end
    case ({fire, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_base_d  = out_base_q;
    if (!out_valid_q || out_ready) begin
      out_valid_d = done_d[head_d];
      if (done_d[head_d]) begin
        out_data_d = data_d[head_d];
        out_base_d = base_d[head_d];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      done_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_base_q  <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        base_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      pending_q   <= pending_d;
      done_q      <= done_d;
      base_q      <= base_d;
      data_q      <= data_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_base_q  <= out_base_d;
      err_q       <= err_d;
    end
  end

  assign tail      = tail_q;
  assign full      = count_q == FULL_CNT;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_base  = out_base_q;
  assign err_tag   = err_q;
endmodule

// File: rtl/base_router_rob.sv
// Base router front end: picks a base per op, dispatches to that ALU channel with zero
// added latency, and keeps per-base dispatch counters; ordering lives in rob_ctrl.
module base_router_rob
  import base_router_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int TAG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic               stats_clr,
  base_router_rob_if.slave   bus,
  output logic [CNT_W-1:0]   cnt_base2,
  output logic [CNT_W-1:0]   cnt_base10,
  output logic [CNT_W-1:0]   cnt_base12,
  output logic               err_tag
);
  logic [1:0]       sel;
  logic [2:0]       sel_oh;
  logic             rob_full, fire;
  logic [TAG_W-1:0] tail;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  assign sel    = select_base(32'(bus.in_a), 32'(bus.in_b), bus.in_op, mode);
  assign sel_oh = 3'b001 << sel;

  // in_ready looks only at the registered count, so a retire never frees a slot for the same cycle.
  assign bus.alu_req_valid = (bus.in_valid && !rob_full && !reset) ? sel_oh : 3'b000;
  assign bus.in_ready      = !rob_full && !reset && |(sel_oh & bus.alu_req_ready);
  assign fire              = bus.in_valid && bus.in_ready;
  assign bus.alu_req_a     = bus.in_a;
  assign bus.alu_req_b     = bus.in_b;
  assign bus.alu_req_op    = bus.in_op;
  assign bus.alu_req_tag   = tail;

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      cnt_d[c] = cnt_q[c];
      if (stats_clr) begin
        cnt_d[c] = '0;
      end else if (fire && sel == 2'(c) && cnt_q[c] != '1) begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 3; c++) cnt_q[c] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_base2  = cnt_q[0];
  assign cnt_base10 = cnt_q[1];
  assign cnt_base12 = cnt_q[2];

  rob_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_rob (
    .clk       (clk),
    .rst       (reset),
    .fire      (fire),
    .fire_base (sel),
    .rsp_valid (bus.alu_rsp_valid),
    .rsp_data  (bus.alu_rsp_data),
    .rsp_tag   (bus.alu_rsp_tag),
    .out_ready (bus.out_ready),
    .tail      (tail),
    .full      (rob_full),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data),
    .out_base  (bus.out_base),
    .err_tag   (err_tag)
  );
endmodule

// File: tb/tb_base_router_rob.sv
// Directed bench for base_router_rob: selection, dispatch, out-of-order retire,
// back-pressure, full ROB, tag errors, reset mid-run and counter saturation/clear.
module tb_base_router_rob;
  import base_router_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       stats_clr;
  logic [3:0] cnt_base2, cnt_base10, cnt_base12;
  logic       err_tag;

  int n_checks = 0;
  int n_errors = 0;
  int n_ret    = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  base_router_rob_if #(.WIDTH(16), .TAG_W(3)) bus ();

  base_router_rob #(.WIDTH(16), .DEPTH(8), .TAG_W(3), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .stats_clr  (stats_clr),
    .bus        (bus),
    .cnt_base2  (cnt_base2),
    .cnt_base10 (cnt_base10),
    .cnt_base12 (cnt_base12),
    .err_tag    (err_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
  endtask

  task automatic rsp(input int c, input logic [2:0] tag, input logic [15:0] data);
    bus.alu_rsp_valid[c]          = 1'b1;
    bus.alu_rsp_tag[c*3 +: 3]     = tag;
    bus.alu_rsp_data[c*16 +: 16]  = data;
  endtask

  task automatic clr_rsp();
    bus.alu_rsp_valid = 3'b000;
  endtask

  task automatic sel_probe(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] op, input logic [1:0] m, input logic [2:0] exp);
    mode = m;
    drive(a, b, op);
    #1;
    check(tag, 32'(bus.alu_req_valid), 32'(exp));
  endtask

  task automatic out_chk(input string tag, input logic [15:0] data, input logic [1:0] base);
    check({tag, "_valid"}, 32'(bus.out_valid), 1);
    check({tag, "_data"}, 32'(bus.out_data), 32'(data));
    check({tag, "_base"}, 32'(bus.out_base), 32'(base));
  endtask

  initial begin
    reset = 1'b1; mode = MODE_AUTO; stats_clr = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = '0; bus.in_b = '0; bus.in_op = OP_ADD;
    bus.alu_req_ready = 3'b111; bus.alu_rsp_valid = 3'b000;
    bus.alu_rsp_data = '0; bus.alu_rsp_tag = '0; bus.out_ready = 1'b1;

    // Reset state
    @(posedge clk); #1;
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_req_valid", 32'(bus.alu_req_valid), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_cnt2", 32'(cnt_base2), 0);
    check("rst_err", 32'(err_tag), 0);
    @(negedge clk);
    reset = 1'b0; bus.in_valid = 1'b0;
    cyc();

    // Auto ADD 24+36 goes to base12, result one cycle after the response
    drive(16'd24, 16'd36, OP_ADD); #1;
    check("a_req_valid", 32'(bus.alu_req_valid), 32'h4);
    check("a_req_tag", 32'(bus.alu_req_tag), 0);
    check("a_in_ready", 32'(bus.in_ready), 1);
    check("a_req_a", 32'(bus.alu_req_a), 24);
    cyc(); bus.in_valid = 1'b0;
    rsp(2, 3'd0, 16'd60); #1;
    check("a_out_early", 32'(bus.out_valid), 0);
    check("a_cnt12", 32'(cnt_base12), 1);
    cyc(); clr_rsp(); #1;
    out_chk("a_out", 16'd60, 2'd2);
    cyc(); #1;
    check("a_out_gone", 32'(bus.out_valid), 0);

    // Selection table, channels not ready so nothing dispatches
    bus.alu_req_ready = 3'b000;
    sel_probe("s_div4", 16'd100, 16'd4, OP_DIV, MODE_AUTO, 3'b100);
    sel_probe("s_div5", 16'd100, 16'd5, OP_DIV, MODE_AUTO, 3'b010);
    sel_probe("s_div7", 16'd100, 16'd7, OP_DIV, MODE_AUTO, 3'b001);
    sel_probe("s_div3", 16'd9, 16'd3, OP_DIV, MODE_AUTO, 3'b100);
    sel_probe("s_add10", 16'd20, 16'd30, OP_ADD, MODE_AUTO, 3'b010);
    sel_probe("s_add0", 16'd0, 16'd0, OP_ADD, MODE_AUTO, 3'b100);
    sel_probe("s_mul_or", 16'd24, 16'd7, OP_MUL, MODE_AUTO, 3'b100);
    sel_probe("s_or", 16'd24, 16'd24, OP_OR, MODE_AUTO, 3'b001);
    sel_probe("s_xor", 16'd20, 16'd30, OP_XOR, MODE_AUTO, 3'b001);
    sel_probe("s_shr", 16'd12, 16'd12, OP_SHR, MODE_B12, 3'b001);
    sel_probe("s_shl", 16'd12, 16'd12, OP_SHL, MODE_B10, 3'b001);
    sel_probe("s_op9", 16'd12, 16'd12, 4'd9, MODE_B12, 3'b001);
    sel_probe("s_sub_f10", 16'd7, 16'd3, OP_SUB, MODE_B10, 3'b010);
    sel_probe("s_add_f2", 16'd24, 16'd36, OP_ADD, MODE_B2, 3'b001);
    check("s_in_ready", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b0; bus.alu_req_ready = 3'b111; mode = MODE_AUTO;
    cyc();

    // MUL 7*10 -> base10, AND of multiples of 12 -> base2, forced base12 SUB
    drive(16'd7, 16'd10, OP_MUL); #1;
    check("b_mul_valid", 32'(bus.alu_req_valid), 32'h2);
    check("b_mul_tag", 32'(bus.alu_req_tag), 1);
    cyc();
    drive(16'd12, 16'd12, OP_AND); #1;
    check("b_and_valid", 32'(bus.alu_req_valid), 32'h1);
    check("b_and_tag", 32'(bus.alu_req_tag), 2);
    cyc();
    mode = MODE_B12;
    drive(16'd7, 16'd3, OP_SUB); #1;
    check("b_sub_valid", 32'(bus.alu_req_valid), 32'h4);
    cyc(); bus.in_valid = 1'b0; mode = MODE_AUTO;
    rsp(1, 3'd1, 16'd70); rsp(0, 3'd2, 16'd12); rsp(2, 3'd3, 16'd4); #1;
    check("b_out_early", 32'(bus.out_valid), 0);
    cyc(); clr_rsp(); #1;
    out_chk("b_out0", 16'd70, 2'd1);
    cyc(); #1;
    out_chk("b_out1", 16'd12, 2'd0);
    cyc(); #1;
    out_chk("b_out2", 16'd4, 2'd2);
    check("b_cnt2", 32'(cnt_base2), 1);
    check("b_cnt10", 32'(cnt_base10), 1);
    check("b_cnt12", 32'(cnt_base12), 2);
    cyc(); #1;
    check("b_out_gone", 32'(bus.out_valid), 0);

    // Out-of-order return on three channels, in-order retire
    mode = MODE_B2;  drive(16'd1, 16'd2, OP_ADD); #1;
    check("c_tag4", 32'(bus.alu_req_tag), 4);
    cyc();
    mode = MODE_B10; drive(16'd3, 16'd4, OP_ADD); #1;
    check("c_valid10", 32'(bus.alu_req_valid), 32'h2);
    cyc();
    mode = MODE_B12; drive(16'd5, 16'd6, OP_ADD); #1;
    check("c_tag6", 32'(bus.alu_req_tag), 6);
    cyc(); bus.in_valid = 1'b0; mode = MODE_AUTO;
    exp_q.push_back(16'd100); exp_q.push_back(16'd200); exp_q.push_back(16'd300);
    rsp(2, 3'd6, 16'd300); #1;
    check("c_wait0", 32'(bus.out_valid), 0);
    cyc(); clr_rsp(); rsp(1, 3'd5, 16'd200); #1;
    check("c_wait1", 32'(bus.out_valid), 0);
    cyc(); clr_rsp(); rsp(0, 3'd4, 16'd100); #1;
    check("c_wait2", 32'(bus.out_valid), 0);
    cyc(); clr_rsp();
    for (int i = 0; i < 3; i++) begin
      #1;
      exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      check("c_ret_valid", 32'(bus.out_valid), 1);
      check("c_ret_data", 32'(bus.out_data), 32'(exp_v));
      cyc();
    end
    #1;
    check("c_ret_done", 32'(bus.out_valid), 0);
    check("c_cnt12", 32'(cnt_base12), 3);

    // Back-pressure: result held stable for three cycles
    bus.out_ready = 1'b0;
    mode = MODE_B10; drive(16'd1, 16'd1, OP_ADD); #1;
    check("d_tag7", 32'(bus.alu_req_tag), 7);
    cyc();
    mode = MODE_B2; drive(16'd2, 16'd2, OP_ADD); #1;
    check("d_tag0", 32'(bus.alu_req_tag), 0);
    cyc(); bus.in_valid = 1'b0; mode = MODE_AUTO;
    rsp(1, 3'd7, 16'h1234); rsp(0, 3'd0, 16'h5678);
    cyc(); clr_rsp();
    for (int i = 0; i < 3; i++) begin
      #1;
      out_chk("d_hold", 16'h1234, 2'd1);
      cyc();
    end
    bus.out_ready = 1'b1; #1;
    out_chk("d_rel", 16'h1234, 2'd1);
    cyc(); #1;
    out_chk("d_next", 16'h5678, 2'd0);
    check("d_cnt10", 32'(cnt_base10), 3);
    cyc();

    // Fill all eight slots, ninth op refused, one retire reopens the input
    mode = MODE_B2;
    for (int i = 0; i < 8; i++) begin
      drive(16'(i), 16'(i), OP_ADD); #1;
      check("e_fill_ready", 32'(bus.in_ready), 1);
      check("e_fill_tag", 32'(bus.alu_req_tag), 32'((1 + i) % 8));
      cyc();
    end
    #1;
    check("e_full_ready", 32'(bus.in_ready), 0);
    check("e_full_valid", 32'(bus.alu_req_valid), 0);
    check("e_cnt2", 32'(cnt_base2), 11);
    bus.in_valid = 1'b0;
    rsp(0, 3'd1, 16'h0055);
    cyc(); clr_rsp(); #1;
    out_chk("e_head", 16'h0055, 2'd0);
    check("e_still_full", 32'(bus.in_ready), 0);
    cyc(); #1;
    check("e_reopen", 32'(bus.in_ready), 1);
    check("e_next_wait", 32'(bus.out_valid), 0);

    // Wrong-channel response: sticky error, slot untouched
    rsp(1, 3'd2, 16'hdead); #1;
    check("f_err_pre", 32'(err_tag), 0);
    cyc(); clr_rsp(); #1;
    check("f_err_set", 32'(err_tag), 1);
    check("f_rob_same", 32'(bus.out_valid), 0);
    cyc(); #1;
    check("f_err_sticky", 32'(err_tag), 1);
    rsp(0, 3'd2, 16'h0077);
    cyc(); clr_rsp(); #1;
    out_chk("f_good", 16'h0077, 2'd0);

    // Reset with ops outstanding
    drive(16'd3, 16'd3, OP_ADD);
    reset = 1'b1; #1;
    check("g_out_valid", 32'(bus.out_valid), 0);
    check("g_out_data", 32'(bus.out_data), 0);
    check("g_in_ready", 32'(bus.in_ready), 0);
    check("g_req_valid", 32'(bus.alu_req_valid), 0);
    check("g_cnt2", 32'(cnt_base2), 0);
    check("g_cnt10", 32'(cnt_base10), 0);
    check("g_err", 32'(err_tag), 0);
    cyc(); reset = 1'b0; bus.in_valid = 1'b0;

    // Late response to an empty ROB
    rsp(0, 3'd5, 16'h0099);
    cyc(); clr_rsp(); #1;
    check("h_late_err", 32'(err_tag), 1);
    check("h_late_rob", 32'(bus.out_valid), 0);

    // Seventeen base2 dispatches through a short pipeline: counter saturates at 15
    for (int i = 0; i < 18; i++) begin
      if (i < 17) drive(16'(i), 16'd1, OP_ADD);
      else bus.in_valid = 1'b0;
      clr_rsp();
      if (i > 0) begin
        rsp(0, 3'(i - 1), 16'(16'h200 + i - 1));
        exp_q.push_back(16'(16'h200 + i - 1));
      end
      #1;
      if (i < 17) check("i_tag", 32'(bus.alu_req_tag), 32'(i % 8));
      if (bus.out_valid) begin
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        check("i_ret_data", 32'(bus.out_data), 32'(exp_v));
        n_ret++;
      end
      cyc();
    end
    clr_rsp();
    for (int i = 0; i < 2; i++) begin
      #1;
      if (bus.out_valid) begin
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        check("i_ret_data", 32'(bus.out_data), 32'(exp_v));
        n_ret++;
      end
      cyc();
    end
    check("i_retired", 32'(n_ret), 17);
    check("i_cnt2_sat", 32'(cnt_base2), 15);
    check("i_cnt12", 32'(cnt_base12), 0);

    // stats_clr wins over a same-cycle dispatch
    drive(16'd1, 16'd1, OP_ADD); stats_clr = 1'b1;
    cyc(); stats_clr = 1'b0; bus.in_valid = 1'b0; #1;
    check("j_clr", 32'(cnt_base2), 0);
    drive(16'd1, 16'd1, OP_ADD);
    cyc(); bus.in_valid = 1'b0; #1;
    check("j_count_again", 32'(cnt_base2), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
